// File: rtl/range_tracker_pkg.sv
// Shared types and default sizes for the range_tracker block.
package range_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH     = 10;
  localparam int DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/range_tracker_minmax_update.sv
// Combinational min/max update for one sample; signed compare when
// RANGE_TRACKER_SIGNED_EN is defined, unsigned otherwise.
module minmax_update
  import range_tracker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic             first,
  output logic [WIDTH-1:0] next_min,
  output logic [WIDTH-1:0] next_max
);

  logic below;
  logic above;

`ifdef RANGE_TRACKER_SIGNED_EN
  assign below = $signed(sample) < $signed(cur_min);
  assign above = $signed(sample) > $signed(cur_max);
`else
  assign below = sample < cur_min;
  assign above = sample > cur_max;
`endif

  // Min and max move independently, so one sample can update both.
  assign next_min = (first || below) ? sample : cur_min;
  assign next_max = (first || above) ? sample : cur_max;

endmodule

// File: rtl/range_tracker.sv
// Tracks min/max/range/count of a qualified stream between go and finish.
// Optional signed compare: define RANGE_TRACKER_SIGNED_EN.
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     range_out,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 busy,
  output logic                 done,
  output logic                 debug_error,
  output state_t               state_dbg
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic             have_sample;
  logic             start;
  logic             accept;
  logic             first;
  logic [WIDTH-1:0] next_min;
  logic [WIDTH-1:0] next_max;

  // start: a go that (re)initialises a measurement; finish wins except in ERROR.
  always_comb begin
    start = 1'b0;
    case (state)
      IDLE, RUN: start = go && !finish;
      ERROR:     start = go;
      default:   start = 1'b0;
    endcase
  end

  assign accept    = valid_in && (start || (state == RUN));
  assign first     = start || !have_sample;
  assign range_out = max_out - min_out;
  assign state_dbg = state;

  minmax_update #(.WIDTH(WIDTH)) u_minmax (
    .sample   (data_in),
    .cur_min  (min_out),
    .cur_max  (max_out),
    .first    (first),
    .next_min (next_min),
    .next_max (next_max)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      have_sample <= 1'b0;
      min_out     <= '0;
      max_out     <= '0;
      count_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      debug_error <= 1'b0;
    end else begin
      if (start) begin
        have_sample <= accept;
        min_out     <= accept ? next_min : '0;
        max_out     <= accept ? next_max : '0;
        count_out   <= accept ? CNT_WIDTH'(1) : '0;
      end else if (accept) begin
        have_sample <= 1'b1;
        min_out     <= next_min;
        max_out     <= next_max;
        if (count_out != CNT_MAX) count_out <= count_out + 1'b1;
      end

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (finish) begin
            state       <= ERROR;
            debug_error <= 1'b1;
          end else if (go) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (finish) begin
            busy <= 1'b0;
            if (have_sample || valid_in) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= ERROR;
              debug_error <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        ERROR: begin
          if (go) begin
            state       <= RUN;
            busy        <= 1'b1;
            debug_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_tracker.sv
// Bench for range_tracker: vector table, hand sequences, random vs. model.
module tb_range_tracker;
  import range_tracker_pkg::*;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic         go = 1'b0;
  logic         finish = 1'b0;

  logic [W-1:0] a_min, a_max, a_rng, b_min, b_max, b_rng;
  logic [7:0]   a_cnt;
  logic [3:0]   b_cnt;
  logic         a_busy, a_done, a_err, b_busy, b_done, b_err;
  state_t       a_st, b_st;

  int n_cmp = 0;
  int n_err = 0;

  range_tracker #(.WIDTH(W), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
    .go(go), .finish(finish), .min_out(a_min), .max_out(a_max), .range_out(a_rng),
    .count_out(a_cnt), .busy(a_busy), .done(a_done), .debug_error(a_err),
    .state_dbg(a_st)
  );

  range_tracker #(.WIDTH(W), .CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in),
    .go(go), .finish(finish), .min_out(b_min), .max_out(b_max), .range_out(b_rng),
    .count_out(b_cnt), .busy(b_busy), .done(b_done), .debug_error(b_err),
    .state_dbg(b_st)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 measuring, 2 done pulse, 3 error;
  // the current measurement is the list of accepted samples.
  int           m_phase = 0;
  logic [W-1:0] m_samp[$];

  function automatic bit lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RANGE_TRACKER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  function automatic state_t ph2st(input int p);
    case (p)
      1: return RUN;
      2: return DONE;
      3: return ERROR;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_start(input logic v, input logic [W-1:0] d);
    m_samp.delete();
    if (v) m_samp.push_back(d);
    m_phase = 1;
  endtask

  task automatic model_edge(input logic g, input logic f, input logic v, input logic [W-1:0] d);
    case (m_phase)
      0: if (f) m_phase = 3; else if (g) model_start(v, d);
      1: begin
        if (f) begin
          if (v) m_samp.push_back(d);
          m_phase = (m_samp.size() > 0) ? 2 : 3;
        end else if (g) model_start(v, d);
        else if (v) m_samp.push_back(d);
      end
      2: m_phase = 0;
      default: if (g) model_start(v, d);
    endcase
  endtask

  task automatic model_reset();
    m_samp.delete();
    m_phase = 0;
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] mn, mx, rg;
    int n;
    n = m_samp.size();
    mn = '0;
    mx = '0;
    if (n > 0) begin
      mn = m_samp[0];
      mx = m_samp[0];
      foreach (m_samp[i]) begin
        if (lt(m_samp[i], mn)) mn = m_samp[i];
        if (lt(mx, m_samp[i])) mx = m_samp[i];
      end
    end
    rg = mx - mn;
    chk({tag, ".min"},   a_min, mn);
    chk({tag, ".max"},   a_max, mx);
    chk({tag, ".range"}, a_rng, rg);
    chk({tag, ".cnt8"},  a_cnt, (n > 255) ? 255 : n);
    chk({tag, ".cnt4"},  b_cnt, (n > 15) ? 15 : n);
    chk({tag, ".min4"},  b_min, mn);
    chk({tag, ".max4"},  b_max, mx);
    chk({tag, ".busy"},  {a_busy, b_busy}, {2{m_phase == 1}});
    chk({tag, ".done"},  {a_done, b_done}, {2{m_phase == 2}});
    chk({tag, ".err"},   {a_err, b_err}, {2{m_phase == 3}});
    chk({tag, ".state"}, {a_st, b_st}, {ph2st(m_phase), ph2st(m_phase)});
  endtask

  task automatic cycle(input logic g, input logic f, input logic v, input logic [W-1:0] d);
    go = g;
    finish = f;
    valid_in = v;
    data_in = d;
    @(posedge clock);
    model_edge(g, f, v, d);
    #1;
  endtask

  typedef struct {
    logic         g, f, v;
    logic [W-1:0] d, emin, emax, erng;
    int           ecnt;
    logic         ebusy, edone, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic g, input logic f, input logic v, input logic [W-1:0] d,
                              input logic [W-1:0] mn, input logic [W-1:0] mx, input logic [W-1:0] rg,
                              input int c, input logic b, input logic dn, input logic e);
    vec_t r;
    r.g = g; r.f = f; r.v = v; r.d = d;
    r.emin = mn; r.emax = mx; r.erng = rg; r.ecnt = c;
    r.ebusy = b; r.edone = dn; r.eerr = e;
    return r;
  endfunction

  initial begin
`ifdef RANGE_TRACKER_SIGNED_EN
    vecs.push_back(mk(1, 0, 1, 10'h200, 10'h200, 10'h200, 0,       1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h1FF, 10'h200, 10'h1FF, 10'h3FF, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h000, 10'h200, 10'h1FF, 10'h3FF, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       10'h200, 10'h1FF, 10'h3FF, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,       10'h200, 10'h1FF, 10'h3FF, 3, 0, 0, 0));
`else
    vecs.push_back(mk(1, 0, 1, 100,  100, 100,  0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40,   40,  100,  60,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 700,  40,  700,  660, 3, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 300,  40,  700,  660, 4, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    40,  700,  660, 4, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    40,  700,  660, 4, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 50,   50,  50,   0,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 30,   30,  50,   20,  2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1023, 30,  1023, 993, 3, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,    30,  1023, 993, 3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    30,  1023, 993, 3, 0, 0, 0));
`endif
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,   0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5,   5,   5,   0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9,   5,   9,   4, 2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 200, 200, 200, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,   200, 200, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   200, 200, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,   200, 200, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   200, 200, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,   0,   0,   0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,   0,   0,   0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 7,   7,   7,   0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8,   7,   8,   1, 2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 99,  7,   8,   1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0,   7,   8,   1, 2, 0, 0, 1));

    // Reset values.
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.min", a_min, 0);
    chk("rst.max", a_max, 0);
    chk("rst.range", a_rng, 0);
    chk("rst.cnt", a_cnt, 0);
    chk("rst.flags", {a_busy, a_done, a_err, b_busy, b_done, b_err}, 0);
    chk("rst.state", a_st, IDLE);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].g, vecs[i].f, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d.min", i),   a_min, vecs[i].emin);
      chk($sformatf("vec%0d.max", i),   a_max, vecs[i].emax);
      chk($sformatf("vec%0d.range", i), a_rng, vecs[i].erng);
      chk($sformatf("vec%0d.cnt", i),   a_cnt, vecs[i].ecnt);
      chk($sformatf("vec%0d.cnt4", i),  b_cnt, vecs[i].ecnt);
      chk($sformatf("vec%0d.flags", i), {a_busy, a_done, a_err},
          {vecs[i].ebusy, vecs[i].edone, vecs[i].eerr});
    end

    // Results held while nothing happens.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      chk("hold.minmax", {a_min, a_max}, {10'd7, 10'd8});
      chk("hold.cnt", a_cnt, 2);
      chk("hold.done", a_done, 0);
    end

    // Saturation with gaps; invalid-cycle data must not leak into min/max.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, W'(10 + 3 * i));
      cycle(0, 0, 0, (i % 2 == 1) ? 10'd1023 : 10'd0);
    end
    chk("sat.cnt4_run", b_cnt, 15);
    cycle(0, 1, 0, 0);
    chk("sat.done", {a_done, b_done}, 2'b11);
    chk("sat.cnt8", a_cnt, 20);
    chk("sat.cnt4", b_cnt, 15);
    chk("sat.min", a_min, 10);
    chk("sat.max", a_max, 67);
    chk("sat.range", a_rng, 57);
    cycle(0, 0, 0, 0);

    // Asynchronous reset in the middle of a measurement.
    cycle(1, 0, 1, 300);
    cycle(0, 0, 1, 5);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_model("arst");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      chk("arst.no_done", {a_done, b_done}, 0);
      check_model("arst_after");
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1, W'($urandom_range(0, 1023)));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/range_tracker.md
# range_tracker

Parametrised successor to the single-shot 10-bit range finder. Tracks the minimum, maximum, range and sample count of a qualified data stream between a `go` and a `finish` command. Holds the results until the next measurement starts and flags protocol errors. Sits on the datapath output, feeding the status and debug readout.

## Interface
- `WIDTH`, default 10: data width in bits.
- `CNT_WIDTH`, default 8: sample-counter width in bits.
- `clock` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `data_in` input WIDTH: sample, used only when `valid_in`=1.
- `valid_in` input 1: sample qualifier.
- `go` input 1: start, or restart, a measurement.
- `finish` input 1: end the measurement.
- `min_out` output WIDTH: registered minimum.
- `max_out` output WIDTH: registered maximum.
- `range_out` output WIDTH: `max_out - min_out`, combinational from the registers.
- `count_out` output CNT_WIDTH: number of accepted samples, saturating.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse in DONE.
- `debug_error` output 1: Moore output, high in ERROR.

## Operation
- States (shared enum): IDLE, RUN, DONE, ERROR.
- **IDLE**
  - `finish`=1 -> ERROR. `finish` takes priority over a simultaneous `go`.
  - Otherwise `go`=1 -> RUN. Clear `count_out` and the internal `have_sample` flag.
  - If `valid_in` is also high on the `go` cycle, that sample is the first sample.
- **RUN**
  - `finish`=1 -> DONE if at least one sample was accepted, including one on the `finish` cycle itself.
  - `finish`=1 with zero samples -> ERROR.
  - `go`=1 without `finish` -> restart: count cleared, and the `go`-cycle sample, if valid, becomes the first sample.
  - `finish` has priority over `go`.
- **DONE**: lasts one cycle, then IDLE. `done`=1 during this cycle.
- **ERROR**
  - `go`=1 -> RUN, with the same initialisation as in IDLE.
  - `finish` is ignored.
- **Sample acceptance** (RUN, or the `go` cycle):
  - First sample loads both min and max.
  - Later samples update min and max independently, so a single sample can move both.
  - Count increments by 1 per accepted sample and saturates at 2^CNT_WIDTH−1.
- **Result hold**: `min_out`, `max_out` and `count_out` keep their values through DONE, IDLE and ERROR until the next `go`.
- **Arithmetic**
  - `range_out` is WIDTH bits, unsigned, modulo 2^WIDTH. It never overflows because max ≥ min.
  - Comparisons are unsigned by default; see Configuration.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state IDLE.
  - `min_out`, `max_out`, `count_out` = 0, so `range_out` = 0.
  - `busy`, `done`, `debug_error` = 0.
- A sample accepted at edge N is visible on `min_out`/`max_out`/`range_out`/`count_out` after edge N, i.e. 1-cycle latency.
- `done` is high in the cycle after the edge at which `finish` was sampled. Results are final in that same cycle.
- `busy` rises the cycle after `go` is sampled and falls the cycle after `finish` is sampled.
- `reset_n` asserted mid-RUN: all outputs return to reset values immediately. No `done` pulse.

## Configuration
- `RANGE_TRACKER_SIGNED_EN` defined:
  - `data_in`, `min_out` and `max_out` are two's complement; comparisons are signed.
  - `range_out` stays unsigned WIDTH bits. It is exact because max−min ≤ 2^WIDTH−1.
- Not defined: all comparisons are unsigned.
- Reset values and the state machine are identical in both builds.

## Structure
- Package `range_tracker_pkg` holds:
  - `state_t` (2-bit enum: IDLE, RUN, DONE, ERROR).
  - Default localparams `DEFAULT_WIDTH`=10 and `DEFAULT_CNT_WIDTH`=8.
- Sub-module `minmax_update`:
  - Purely combinational, parametrised by WIDTH.
  - Inputs: sample, current min/max, `first` flag.
  - Outputs: next min/max.
  - The signed/unsigned compare selection lives only here, under `RANGE_TRACKER_SIGNED_EN`.
- Top level holds the FSM, the registers and the saturating counter.

## Test plan
- Reset/basic: deassert reset; `go`+valid 100, then valid 40, 700, 300, `finish` -> `done` pulse, min 40, max 700, range 660, count 4.
- Dual update:
  - `go`+valid 50; valid 30 -> min 30, max 50.
  - Valid 1023 -> max 1023, min 30, range 993.
- Errors:
  - `finish` in IDLE -> `debug_error`=1 from the next cycle; `go` -> RUN, `debug_error`=0.
  - `go` then `finish` with `valid_in` never high -> ERROR, results 0.
- Restart/hold:
  - `go`, samples 5 and 9, `go`+valid 200, `finish` -> min 200, max 200, count 1.
  - Results unchanged for 10 idle cycles.
- Saturation/gaps: CNT_WIDTH=4, 20 valid samples interleaved with `valid_in`=0 cycles -> count 15. Invalid cycles do not affect min/max.
- Signed build (`RANGE_TRACKER_SIGNED_EN`, WIDTH=10): samples −512, 511, 0 -> min −512 (0x200), max 511, range 1023. Mid-RUN `reset_n` pulse -> all outputs 0, no `done`.
